mmio_uart_duplex: RTL and testbench

Memory-mapped full-duplex UART: parametrised TX and RX FIFOs, a runtime-programmable baud divisor, and a status register with sticky error flags. Successor to the TX-only MMIO UART. Sits on the core's MMIO bus behind the address decoder and uses the same req/resp handshake as the other MMIO slaves.

---
 rtl/mmio_uart_duplex_pkg.sv | 29 ++
 rtl/mmio_uart_duplex_if.sv | 15 +
 rtl/mmio_uart_duplex_fifo.sv | 47 ++++
 rtl/mmio_uart_duplex.sv | 226 ++++++++++++++++++++++
 tb/tb_mmio_uart_duplex.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_duplex_pkg.sv
// Shared register map, status bit positions and types for the duplex MMIO UART.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_TX_EMPTY     = 1;
  localparam int STAT_RX_EMPTY     = 2;
  localparam int STAT_RX_OVERRUN   = 3;
  localparam int STAT_RX_FRAME_ERR = 4;
  localparam int STAT_TX_BUSY      = 5;

  typedef logic [7:0]  UInt8;
  typedef logic [15:0] UartDiv;

  localparam UartDiv DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} TxState;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} RxState;

  // Divisors below 4 leave no room for a mid-bit sample, so they are raised.
  function automatic UartDiv clamp_div(input UartDiv d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/mmio_uart_duplex_if.sv
// MMIO req/resp handshake shared by the core's memory-mapped slaves.
interface mmio_uart_duplex_if #(parameter int XLEN = 32);
  logic            req_ready;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_wen;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;

  modport master (input req_ready, resp_valid, resp_rdata,
                  output req_valid, req_addr, req_wen, req_wdata);
  modport slave (output req_ready, resp_valid, resp_rdata,
                 input req_valid, req_addr, req_wen, req_wdata);
endinterface

// File: rtl/mmio_uart_duplex_fifo.sv
// Synchronous FIFO with full/empty flags; push and pop may occur in the same cycle.
module uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/mmio_uart_duplex.sv
// Memory-mapped full-duplex UART: TX/RX FIFOs, programmable divisor, sticky RX error flags.
module mmio_uart_duplex
  import uart_pkg::*;
#(
  parameter int FMAX_MHz      = 27,
  parameter int BAUD          = 115200,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int XLEN          = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               uart_tx,
  input  logic               uart_rx,
  mmio_uart_duplex_if.slave  bus
);

  localparam UartDiv DIV_RST = UartDiv'((FMAX_MHz * 1000000) / BAUD);

  localparam logic [1:0] TS_IDLE  = TX_IDLE;
  localparam logic [1:0] TS_START = TX_START;
  localparam logic [1:0] TS_DATA  = TX_DATA;
  localparam logic [1:0] TS_STOP  = TX_STOP;
  localparam logic [1:0] RS_IDLE  = RX_IDLE;
  localparam logic [1:0] RS_START = RX_START;
  localparam logic [1:0] RS_DATA  = RX_DATA;
  localparam logic [1:0] RS_STOP  = RX_STOP;

  logic       accept, wr_tx, rd_rx, wr_stat, wr_div;
  logic [1:0] reg_sel;
  UartDiv     div;
  logic       tx_full, tx_empty, tx_pop, tx_busy, tx_last;
  UInt8       tx_head, tx_shift;
  logic [1:0] tx_state;
  UartDiv     tx_cnt, tx_div;
  logic [2:0] tx_bit;
  logic       rx_meta, rx_sync, rx_prev;
  logic       rx_full, rx_empty, rx_pop, rx_push, rx_tick, rx_mid;
  UInt8       rx_head, rx_shift;
  logic [1:0] rx_state;
  UartDiv     rx_cnt, rx_div;
  logic [2:0] rx_bit;
  logic       overrun_set, frame_set, rx_overrun, rx_frame_err;
  logic [5:0] status;
  logic [XLEN-1:0] rd_data;
  logic       unused_bits;

  assign unused_bits   = ^{bus.req_addr[XLEN-1:4], bus.req_addr[1:0], bus.req_wdata[XLEN-1:16]};
  assign bus.req_ready = ~tx_full;
  assign accept  = bus.req_valid & bus.req_ready;
  assign reg_sel = bus.req_addr[3:2];
  assign wr_tx   = accept & bus.req_wen & (reg_sel == REG_TXDATA);
  assign rd_rx   = accept & ~bus.req_wen & (reg_sel == REG_RXDATA);
  assign wr_stat = accept & bus.req_wen & (reg_sel == REG_STATUS);
  assign wr_div  = accept & bus.req_wen & (reg_sel == REG_DIV);
  assign rx_pop  = rd_rx & ~rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .wdata(bus.req_wdata[7:0]),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_shift),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)       div <= DIV_RST;
    else if (wr_div) div <= clamp_div(bus.req_wdata[15:0]);
  end

  // A pop from STOP chains straight into the next START with no idle gap.
  assign tx_last = (tx_cnt == tx_div - 16'd1);
  assign tx_pop  = ~tx_empty & ((tx_state == TS_IDLE) | ((tx_state == TS_STOP) & tx_last));
  assign tx_busy = (tx_state != TS_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TS_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_div   <= DIV_RST;
      uart_tx  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TS_START;
      tx_cnt   <= '0;
      tx_shift <= tx_head;
      tx_div   <= div;
      uart_tx  <= 1'b0;
    end else begin
      tx_cnt <= tx_last ? '0 : tx_cnt + 16'd1;
      case (tx_state)
        TS_START: if (tx_last) begin
          tx_state <= TS_DATA;
          tx_bit   <= '0;
          uart_tx  <= tx_shift[0];
        end
        TS_DATA: if (tx_last) begin
          if (tx_bit == 3'd7) begin
            tx_state <= TS_STOP;
            uart_tx  <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
            uart_tx  <= tx_shift[1];
          end
        end
        TS_STOP: if (tx_last) tx_state <= TS_IDLE;
        default: tx_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_tick = (rx_cnt == rx_div - 16'd1);
  assign rx_mid  = (rx_cnt == (rx_div >> 1) - 16'd1);

  always_comb begin
    rx_push     = 1'b0;
    overrun_set = 1'b0;
    frame_set   = 1'b0;
    if ((rx_state == RS_STOP) && rx_tick) begin
      if (!rx_sync)     frame_set   = 1'b1;
      else if (rx_full) overrun_set = 1'b1;
      else              rx_push     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RS_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_div   <= DIV_RST;
    end else begin
      case (rx_state)
        RS_IDLE: if (rx_prev & ~rx_sync) begin
          rx_state <= RS_START;
          rx_cnt   <= '0;
          rx_div   <= div;
        end
        RS_START: if (rx_mid) begin
          rx_state <= rx_sync ? RS_IDLE : RS_DATA;
          rx_cnt   <= '0;
          rx_bit   <= '0;
        end else rx_cnt <= rx_cnt + 16'd1;
        RS_DATA: if (rx_tick) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_cnt   <= '0;
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RS_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: if (rx_tick) begin
          rx_state <= RS_IDLE;
          rx_cnt   <= '0;
        end else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

  // Set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= overrun_set | (rx_overrun & ~(wr_stat & bus.req_wdata[STAT_RX_OVERRUN]));
      rx_frame_err <= frame_set | (rx_frame_err & ~(wr_stat & bus.req_wdata[STAT_RX_FRAME_ERR]));
    end
  end

  always_comb begin
    status                    = '0;
    status[STAT_TX_FULL]      = tx_full;
    status[STAT_TX_EMPTY]     = tx_empty;
    status[STAT_RX_EMPTY]     = rx_empty;
    status[STAT_RX_OVERRUN]   = rx_overrun;
    status[STAT_RX_FRAME_ERR] = rx_frame_err;
    status[STAT_TX_BUSY]      = tx_busy;
    rd_data = '0;
    case (reg_sel)
      REG_RXDATA: begin
        rd_data[XLEN-1] = rx_empty;
        rd_data[7:0]    = rx_empty ? 8'h00 : rx_head;
      end
      REG_STATUS: rd_data[5:0]  = status;
      REG_DIV:    rd_data[15:0] = div;
      default:    rd_data       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= accept;
      if (accept) bus.resp_rdata <= bus.req_wen ? '0 : rd_data;
    end
  end

  always @(posedge clk) begin
    if (!reset && tx_pop) begin
`ifdef PRINT_DEBUGINFO
      $write("[uart] tx byte 0x%02h\n", tx_head);
`else
      $write("%c", tx_head);
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_duplex.sv
// Scoreboard bench for mmio_uart_duplex: bus reads, serial TX waveform and RX frame injection.
module tb_mmio_uart_duplex;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;
  wire  uart_tx;

  mmio_uart_duplex_if #(.XLEN(32)) bus ();

  mmio_uart_duplex #(.FMAX_MHz(27), .BAUD(115200), .TX_DEPTH_LOG2(4),
                     .RX_DEPTH_LOG2(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .uart_tx(uart_tx), .uart_rx(uart_rx), .bus(bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          bus_timeouts = 0;
  logic [31:0] exp_q [$];
  logic        bit_q [$];

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data, output logic ok);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = {28'b0, idx, 2'b00};
    bus.req_wdata = data;
    while (!bus.req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      bus_timeouts++;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    ok = bus.resp_valid;
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] data, output logic ok);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = {28'b0, idx, 2'b00};
    bus.req_wdata = '0;
    while (!bus.req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      bus_timeouts++;
      ok = 1'b0;
      data = 'x;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    ok = bus.resp_valid;
    data = bus.resp_rdata;
  endtask

  // Expected line level for every clock of one frame at divisor 4.
  task automatic push_frame_bits(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < 4; k++) bit_q.push_back(frame[j]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rx = frame[j];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] got, e;
    logic ok;
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (uart_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    tests_run++;
    if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'd234);
    bus_read(REG_DIV, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL reset_div: got %h resp %b expected %h", got, ok, e); end
    @(negedge clk);
    tests_run++;
    if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL resp_one_cycle: got %b expected 0", bus.resp_valid); end
    exp_q.push_back(32'h06);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL reset_status: got %h resp %b expected %h", got, ok, e); end
  endtask

  task automatic test_divisor;
    logic [31:0] got, e;
    logic ok;
    bus_write(REG_DIV, 32'd2, ok);
    exp_q.push_back(32'd4);
    bus_read(REG_DIV, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL div_clamp: got %h expected %h", got, e); end
    bus_write(REG_DIV, 32'hABCD_03E8, ok);
    tests_run++;
    if (!ok || bus.resp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL write_rdata: got %h expected 0", bus.resp_rdata); end
    exp_q.push_back(32'd1000);
    bus_read(REG_DIV, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL div_write: got %h expected %h", got, e); end
    bus_write(REG_DIV, 32'd4, ok);
  endtask

  task automatic test_tx_frame;
    logic [31:0] got, e;
    logic ok, s;
    int n = 0;
    push_frame_bits(8'h41);
    bus_write(REG_TXDATA, 32'h41, ok);
    while (uart_tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    tests_run++;
    if (uart_tx !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tx_start_timeout: uart_tx %b expected 0 within 50 clocks", uart_tx);
      bit_q.delete();
    end
    for (int i = 0; i < 40 && bit_q.size() > 0; i++) begin
      s = bit_q.pop_front();
      tests_run++;
      if (uart_tx !== s) begin tests_failed++; $display("[TB] FAIL tx_bit_%0d: got %b expected %b", i, uart_tx, s); end
      @(negedge clk);
    end
    tests_run++;
    if (uart_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL tx_frame_len: line %b expected idle 1 after 40 clocks", uart_tx); end
    bus_write(REG_TXDATA, 32'h42, ok);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h26);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL tx_busy_status: got %h expected %h", got, e); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, e;
    logic ok;
    for (int i = 0; i < 17; i++) push_frame_bits(8'h30 + 8'(i));
    fork
      begin
        logic wok;
        for (int i = 0; i < 17; i++) bus_write(REG_TXDATA, 32'h30 + i, wok);
        tests_run++;
        if (bus.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL tx_full_ready: got %b expected 0", bus.req_ready); end
      end
      begin
        logic s;
        int n = 0;
        while (uart_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        tests_run++;
        if (uart_tx !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_start_timeout: uart_tx %b expected 0", uart_tx);
          bit_q.delete();
        end
        for (int i = 0; i < 680 && bit_q.size() > 0; i++) begin
          s = bit_q.pop_front();
          tests_run++;
          if (uart_tx !== s) begin tests_failed++; $display("[TB] FAIL b2b_clk_%0d: got %b expected %b", i, uart_tx, s); end
          @(negedge clk);
        end
      end
    join
    exp_q.push_back(32'h06);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL b2b_done_status: got %h expected %h", got, e); end
    $write("\n");
  endtask

  task automatic test_rx_basic;
    logic [31:0] got, e;
    logic ok;
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(32'h0000_005A);
    exp_q.push_back(32'h8000_0000);
    for (int i = 0; i < 2; i++) begin
      bus_read(REG_RXDATA, got, ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL rx_read_%0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_rx_frame_err;
    logic [31:0] got, e;
    logic ok;
    send_frame(8'h33, 1'b0);
    exp_q.push_back(32'h16);
    exp_q.push_back(32'h8000_0000);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL frame_err_set: got %h expected %h", got, e); end
    bus_read(REG_RXDATA, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL frame_err_empty: got %h expected %h", got, e); end
    bus_write(REG_STATUS, 32'h10, ok);
    exp_q.push_back(32'h06);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL frame_err_clear: got %h expected %h", got, e); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] got, e;
    logic ok;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({24'b0, 8'hA0 + 8'(i)});
      send_frame(8'hA0 + 8'(i), 1'b1);
    end
    bus_read(REG_STATUS, got, ok);
    tests_run++;
    if (!ok || got !== 32'h0A) begin tests_failed++; $display("[TB] FAIL overrun_status: got %h expected %h", got, 32'h0A); end
    exp_q.push_back(32'h8000_0000);
    for (int i = 0; i < 17; i++) begin
      bus_read(REG_RXDATA, got, ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL overrun_read_%0d: got %h expected %h", i, got, e); end
    end
    bus_write(REG_STATUS, 32'h08, ok);
    exp_q.push_back(32'h06);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL overrun_clear: got %h expected %h", got, e); end
  endtask

  task automatic test_rx_glitch;
    logic [31:0] got, e;
    logic ok;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back(32'h06);
    exp_q.push_back(32'h8000_0000);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL glitch_status: got %h expected %h", got, e); end
    bus_read(REG_RXDATA, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL glitch_rxdata: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] got, e;
    logic ok, saw_low;
    bus_write(REG_TXDATA, 32'h55, ok);
    bus_write(REG_TXDATA, 32'h56, ok);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (uart_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL midframe_tx: got %b expected 1", uart_tx); end
    reset = 1'b0;
    saw_low = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    tests_run++;
    if (saw_low !== 1'b0) begin tests_failed++; $display("[TB] FAIL midframe_no_restart: line went low %b expected 0", saw_low); end
    exp_q.push_back(32'h06);
    exp_q.push_back(32'd234);
    bus_read(REG_STATUS, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL midframe_status: got %h expected %h", got, e); end
    bus_read(REG_DIV, got, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || got !== e) begin tests_failed++; $display("[TB] FAIL midframe_div: got %h expected %h", got, e); end
    $write("\n");
  endtask

  task automatic test_bus_health;
    tests_run++;
    if (bus_timeouts !== 0) begin tests_failed++; $display("[TB] FAIL bus_timeouts: got %0d expected 0", bus_timeouts); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    uart_rx       = 1'b1;
    reset         = 1'b1;
    @(negedge clk);
    test_reset;
    test_divisor;
    test_tx_frame;
    test_back_to_back;
    test_rx_basic;
    test_rx_frame_err;
    test_rx_overrun;
    test_rx_glitch;
    test_reset_midframe;
    test_bus_health;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
